// File: rtl/la_capture_pkg.sv
// rtl/la_capture_pkg.sv - shared states, word layout and bookkeeping flags for the capture sequencer
package la_capture_pkg;

    localparam int REP_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    // Memory word is {rep_count, sample}; the sample field sits at bit 0.
    localparam int SAMPLE_LSB = 0;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PRE  = 3'd1;
    localparam state_t ST_POST = 3'd2;
    localparam state_t ST_TAIL = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Bit positions inside the rep field of the bookkeeping word.
    localparam int FLAG_NO_PRE  = 0;
    localparam int FLAG_WRAPPED = 1;

endpackage

// File: rtl/la_rle_packer.sv
// rtl/la_rle_packer.sv - run-length packer: open run registers, saturation and flush decision
module la_rle_packer
    import la_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    force_open,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    flush,
    output logic [REP_W+DATA_W-1:0] flush_word
);

    localparam logic [REP_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] cur_data;
    logic [REP_W-1:0]  cur_cnt;
    logic              extend;

    assign extend     = (cur_cnt != '0) && (data_in == cur_data) &&
                        (cur_cnt != CNT_MAX) && !force_open;
    assign flush      = en && (cur_cnt != '0) && !extend;
    assign flush_word = {cur_cnt, cur_data};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur_data <= '0;
            cur_cnt  <= '0;
        end else if (en) begin
            if (extend) begin
                cur_cnt <= cur_cnt + REP_W'(1);
            end else begin
                cur_data <= data_in;
                cur_cnt  <= REP_W'(1);
            end
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - logic-analyzer capture sequencer: trigger FSM, pre ring, post fill, bookkeeping word
module la_capture_ctrl
    import la_capture_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REP_W     = REP_W_DEF,
    parameter int ADDR_W    = 6,
    parameter int MEM_DEPTH = 64,
    parameter int PRE_TRIG  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [DATA_W-1:0]       trig_value,
    input  logic [DATA_W-1:0]       trig_mask,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [REP_W+DATA_W-1:0] mem_wdata,
    output logic                    busy,
    output logic                    triggered,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_FIRST = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(MEM_DEPTH - 2);
    localparam logic [ADDR_W-1:0] TAIL_ADDR  = ADDR_W'(MEM_DEPTH - 1);

    state_t                  state;
    logic [ADDR_W-1:0]       pre_ptr;
    logic [ADDR_W-1:0]       post_ptr;
    logic [ADDR_W-1:0]       last_pre;
    logic                    pre_wrapped;
    logic                    pre_any;

    logic                    hit;
    logic                    start;
    logic                    pk_en;
    logic                    pk_flush;
    logic [REP_W+DATA_W-1:0] pk_word;
    logic [REP_W-1:0]        bk_rep;

    assign hit   = ((data_in ^ trig_value) & trig_mask) == '0;
    assign start = arm && ((state == ST_IDLE) || (state == ST_DONE));
    assign pk_en = (state == ST_PRE) || (state == ST_POST);

    always_comb begin
        bk_rep               = '0;
        bk_rep[FLAG_WRAPPED] = pre_wrapped;
        bk_rep[FLAG_NO_PRE]  = ~pre_any;
    end

    // The trigger sample always starts a fresh run so it is never merged into pre data.
    la_rle_packer #(
        .DATA_W (DATA_W),
        .REP_W  (REP_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .en         (pk_en),
        .force_open ((state == ST_PRE) && hit),
        .data_in    (data_in),
        .flush      (pk_flush),
        .flush_word (pk_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
            pre_ptr     <= '0;
            post_ptr    <= '0;
            last_pre    <= '0;
            pre_wrapped <= 1'b0;
            pre_any     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state       <= ST_PRE;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        triggered   <= 1'b0;
                        pre_ptr     <= '0;
                        post_ptr    <= '0;
                        last_pre    <= '0;
                        pre_wrapped <= 1'b0;
                        pre_any     <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (pk_flush) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= pre_ptr;
                        mem_wdata <= pk_word;
                        last_pre  <= pre_ptr;
                        pre_any   <= 1'b1;
                        if (pre_ptr == PRE_LAST) begin
                            pre_ptr     <= '0;
                            pre_wrapped <= 1'b1;
                        end else begin
                            pre_ptr <= pre_ptr + ADDR_W'(1);
                        end
                    end
                    if (hit) begin
                        state     <= ST_POST;
                        triggered <= 1'b1;
                        post_ptr  <= POST_FIRST;
                    end
                end
                ST_POST: begin
                    if (pk_flush) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= post_ptr;
                        mem_wdata <= pk_word;
                        post_ptr  <= post_ptr + ADDR_W'(1);
                        if (post_ptr == POST_LAST) begin
                            state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= TAIL_ADDR;
                    mem_wdata <= {bk_rep, DATA_W'(last_pre)};
                    state     <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb/tb_la_capture_ctrl.sv - directed self-checking bench for la_capture_ctrl
module tb_la_capture_ctrl;

    localparam int DATA_W    = 16;
    localparam int REP_W     = 8;
    localparam int ADDR_W    = 6;
    localparam int MEM_DEPTH = 64;
    localparam int PRE_TRIG  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    arm;
    logic [DATA_W-1:0]       data_in;
    logic [DATA_W-1:0]       trig_value;
    logic [DATA_W-1:0]       trig_mask;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [REP_W+DATA_W-1:0] mem_wdata;
    logic                    busy;
    logic                    triggered;
    logic                    done;

    always #5 clk = ~clk;

    la_capture_ctrl #(
        .DATA_W    (DATA_W),
        .REP_W     (REP_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .PRE_TRIG  (PRE_TRIG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .data_in    (data_in),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0] tb_mem [MEM_DEPTH];
    int          tb_wr  [MEM_DEPTH];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_addr] = mem_wdata;
            tb_wr[mem_addr]  = tb_wr[mem_addr] + 1;
        end
    end

    typedef struct {
        logic        arm;
        logic [15:0] data;
        logic        we;
        logic [5:0]  addr;
        logic [23:0] wdata;
        logic        busy;
        logic        trig;
        logic        done;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic [15:0] d);
        arm     = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            tb_mem[i] = '0;
            tb_wr[i]  = 0;
        end
    endtask

    function automatic logic [15:0] cval(input int k);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(k);
        lo = 8'(2 * k + 1);
        return {hi, lo};
    endfunction

    function automatic int pre_writes();
        int s = 0;
        for (int i = 0; i < PRE_TRIG; i++) s += tb_wr[i];
        return s;
    endfunction

    // Feeds a new distinct value every cycle so every POST sample flushes, until done.
    task automatic finish_run(input logic [15:0] start_val);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            step(1'b0, start_val + 16'(n));
            n++;
        end
        chk("finish_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic counter_run(input bit glitch, input string tag);
        clear_mem();
        trig_mask  = 16'hFFFF;
        trig_value = 16'h0205;
        step(1'b1, 16'h0000);
        for (int k = 0; k < 80 && done !== 1'b1; k++) begin
            for (int h = 0; h < 2; h++) begin
                if (done !== 1'b1)
                    step(glitch && ((k == 0 && h == 1) || (k == 20 && h == 0)), cval(k));
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_addr0"}, {8'd0, tb_mem[0]}, 32'h0002_0001);
        chk({tag, "_addr1"}, {8'd0, tb_mem[1]}, 32'h0002_0103);
        chk({tag, "_addr8"}, {8'd0, tb_mem[8]}, 32'h0002_0205);
        chk({tag, "_addr9"}, {8'd0, tb_mem[9]}, 32'h0002_0307);
        for (int a = 10; a < 62; a++)
            chk({tag, "_post"}, {8'd0, tb_mem[a]}, {16'h0002, cval(a - 6)});
        chk({tag, "_addr62"}, {8'd0, tb_mem[62]}, 32'h0002_3871);
        chk({tag, "_addr63"}, {8'd0, tb_mem[63]}, 32'h0000_0001);
        chk({tag, "_pre2to7"}, 32'(pre_writes() - tb_wr[0] - tb_wr[1]), 32'd0);
        chk({tag, "_tail_once"}, 32'(tb_wr[63]), 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clear_mem();
        rst        = 1'b1;
        arm        = 1'b0;
        data_in    = '0;
        trig_value = '0;
        trig_mask  = '0;
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        chk("rst_we",    {31'd0, mem_we},    32'd0);
        chk("rst_addr",  {26'd0, mem_addr},  32'd0);
        chk("rst_wdata", {8'd0, mem_wdata},  32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_trig",  {31'd0, triggered}, 32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        rst = 1'b0;

        // Immediate trigger (mask 0), cycle by cycle.
        tv[0] = '{1'b1, 16'h1111, 1'b0, 6'd0,  24'h00_0000, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 16'h1111, 1'b0, 6'd0,  24'h00_0000, 1'b1, 1'b1, 1'b0};
        tv[2] = '{1'b0, 16'h1111, 1'b0, 6'd0,  24'h00_0000, 1'b1, 1'b1, 1'b0};
        tv[3] = '{1'b0, 16'h2222, 1'b1, 6'd8,  24'h02_1111, 1'b1, 1'b1, 1'b0};
        tv[4] = '{1'b0, 16'h3333, 1'b1, 6'd9,  24'h01_2222, 1'b1, 1'b1, 1'b0};
        tv[5] = '{1'b0, 16'h3333, 1'b0, 6'd0,  24'h00_0000, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 16'h4444, 1'b1, 6'd10, 24'h02_3333, 1'b1, 1'b1, 1'b0};
        clear_mem();
        trig_mask  = 16'h0000;
        trig_value = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            step(tv[i].arm, tv[i].data);
            chk($sformatf("vec%0d_we", i),   {31'd0, mem_we},    {31'd0, tv[i].we});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy},      {31'd0, tv[i].busy});
            chk($sformatf("vec%0d_trig", i), {31'd0, triggered}, {31'd0, tv[i].trig});
            chk($sformatf("vec%0d_done", i), {31'd0, done},      {31'd0, tv[i].done});
            if (tv[i].we) begin
                chk($sformatf("vec%0d_addr", i),  {26'd0, mem_addr}, {26'd0, tv[i].addr});
                chk($sformatf("vec%0d_wdata", i), {8'd0, mem_wdata}, {8'd0, tv[i].wdata});
            end
        end
        finish_run(16'h5000);
        chk("imm_addr11",   {8'd0, tb_mem[11]}, 32'h0001_4444);
        chk("imm_addr62",   {8'd0, tb_mem[62]}, 32'h0001_5032);
        chk("imm_bookkeep", {8'd0, tb_mem[63]}, 32'h0001_0000);
        chk("imm_no_pre",   32'(pre_writes()),  32'd0);
        chk("imm_trig_held", {31'd0, triggered}, 32'd1);

        counter_run(1'b0, "demo");

        // Saturation of a long constant stretch in the pre ring.
        clear_mem();
        trig_mask  = 16'hFFFF;
        trig_value = 16'h5555;
        step(1'b1, 16'h0000);
        for (int i = 0; i < 300; i++) step(1'b0, 16'hAAAA);
        step(1'b0, 16'h5555);
        finish_run(16'h7000);
        chk("sat_addr0",    {8'd0, tb_mem[0]}, 32'h00FF_AAAA);
        chk("sat_addr1",    {8'd0, tb_mem[1]}, 32'h002D_AAAA);
        chk("sat_addr8",    {8'd0, tb_mem[8]}, 32'h0001_5555);
        chk("sat_bookkeep", {8'd0, tb_mem[63]}, 32'h0000_0001);
        chk("sat_addr2",    32'(tb_wr[2]), 32'd0);

        // Ring wrap: 20 single-cycle values before the trigger.
        clear_mem();
        trig_mask  = 16'hFFFF;
        trig_value = 16'hBEEF;
        step(1'b1, 16'h0000);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h1000 + 16'(i));
        step(1'b0, 16'hBEEF);
        finish_run(16'h7000);
        chk("wrap_addr0",    {8'd0, tb_mem[0]}, 32'h0001_1010);
        chk("wrap_addr3",    {8'd0, tb_mem[3]}, 32'h0001_1013);
        chk("wrap_addr7",    {8'd0, tb_mem[7]}, 32'h0001_100F);
        chk("wrap_wr0",      32'(tb_wr[0]), 32'd3);
        chk("wrap_wr4",      32'(tb_wr[4]), 32'd2);
        chk("wrap_bookkeep", {8'd0, tb_mem[63]}, 32'h0002_0003);

        // Reset while post_ptr = 20, then a clean capture.
        clear_mem();
        step(1'b1, 16'h0000);
        step(1'b0, 16'hBEEF);
        begin
            int n = 0;
            bit seen = 0;
            while (!seen && n < 100) begin
                step(1'b0, 16'h2000 + 16'(n));
                if (mem_we === 1'b1 && mem_addr == 6'd19) seen = 1;
                n++;
            end
            chk("rstpost_reached", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        step(1'b0, 16'h3000);
        rst = 1'b0;
        chk("rstpost_we",   {31'd0, mem_we},    32'd0);
        chk("rstpost_busy", {31'd0, busy},      32'd0);
        chk("rstpost_trig", {31'd0, triggered}, 32'd0);
        chk("rstpost_done", {31'd0, done},      32'd0);
        step(1'b0, 16'h3001);
        chk("rstpost_idle_we",   {31'd0, mem_we}, 32'd0);
        chk("rstpost_idle_busy", {31'd0, busy},   32'd0);
        clear_mem();
        trig_mask = 16'h0000;
        step(1'b1, 16'h4000);
        finish_run(16'h4100);
        chk("rearm_addr8",    {8'd0, tb_mem[8]},  32'h0001_4100);
        chk("rearm_addr62",   {8'd0, tb_mem[62]}, 32'h0001_4136);
        chk("rearm_bookkeep", {8'd0, tb_mem[63]}, 32'h0001_0000);
        chk("rearm_no_pre",   32'(pre_writes()),  32'd0);

        counter_run(1'b1, "glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
